// File: rtl/muldiv_pkg.sv
// muldiv_pkg: md_op encodings, sequencer states and iteration count shared by
// muldiv_unit and its single-step datapath.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or, when
// MULDIV_DIV_EN is defined, one restoring-divide step.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
`ifdef MULDIV_DIV_EN
    input  logic           is_div,
    output logic           q_bit,
`endif
    output logic [2*W-1:0] acc_next
);

    logic [W:0] mul_sum;
`ifdef MULDIV_DIV_EN
    logic [W-1:0] trial;
`endif

    // Multiply keeps the multiplier in the low half and shifts it out LSB-first;
    // divide keeps the dividend in the low half and shifts quotient bits in.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
        acc_next = {mul_sum, acc[W-1:1]};
`ifdef MULDIV_DIV_EN
        q_bit = 1'b0;
        // A successful trial leaves a difference below the divisor, so W bits hold it.
        trial = {acc[2*W-2:W], acc[W-1]} - operand;
        if (is_div) begin
            q_bit    = ({acc[2*W-1:W], acc[W-1]} >= {1'b0, operand});
            acc_next = {q_bit ? trial : {acc[2*W-2:W], acc[W-1]}, acc[W-2:0], 1'b0};
        end
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO plus single-cycle MTHI/MTLO.
// Define MULDIV_DIV_EN to build the divide datapath; without it DIV/DIVU are no-ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [2:0]            md_op,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int W = DATA_WIDTH;

    md_state_e      state, state_next;
    logic [5:0]     cnt;
    logic [2*W-1:0] acc, acc_step, product;
    logic [W-1:0]   op_b, hi_q, lo_q, a_mag, b_mag;
    logic           neg_res, done_q;
    logic           signed_op, a_neg, b_neg, accept;
`ifdef MULDIV_DIV_EN
    logic           is_div, neg_rem, div_zero, q_bit, accept_div;
    logic [W-1:0]   a_orig, quo, rem;
`endif

    // Operand conditioning and acceptance, only meaningful while IDLE.
    always_comb begin
        signed_op = (md_op == MD_MULT);
        accept    = start && (state == IDLE) && ((md_op == MD_MULT) || (md_op == MD_MULTU));
`ifdef MULDIV_DIV_EN
        signed_op  = signed_op || (md_op == MD_DIV);
        accept_div = start && (state == IDLE) && ((md_op == MD_DIV) || (md_op == MD_DIVU));
        accept     = accept || accept_div;
`endif
        a_neg = signed_op && a_in[W-1];
        b_neg = signed_op && b_in[W-1];
        a_mag = a_neg ? -a_in : a_in;
        b_mag = b_neg ? -b_in : b_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt == 6'(MD_ITER - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    muldiv_step #(.W(W)) u_step (
        .acc      (acc),
        .operand  (op_b),
`ifdef MULDIV_DIV_EN
        .is_div   (is_div),
        .q_bit    (q_bit),
`endif
        .acc_next (acc_step)
    );

    // Sign correction applied to the magnitude result in FIX.
    always_comb begin
        product = neg_res ? -acc : acc;
`ifdef MULDIV_DIV_EN
        quo = neg_res ? -acc[W-1:0] : acc[W-1:0];
        rem = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            op_b    <= '0;
            neg_res <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= {{W{1'b0}}, a_mag};
                        op_b    <= b_mag;
                        neg_res <= a_neg ^ b_neg;
                        cnt     <= '0;
`ifdef MULDIV_DIV_EN
                        is_div   <= accept_div;
                        neg_rem  <= a_neg;
                        div_zero <= (b_in == '0);
                        a_orig   <= a_in;
`endif
                    end else if (start && (md_op == MD_MTHI)) begin
                        hi_q <= a_in;
                    end else if (start && (md_op == MD_MTLO)) begin
                        lo_q <= a_in;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
`ifdef MULDIV_DIV_EN
                    acc <= {acc_step[2*W-1:1], acc_step[0] | q_bit};
`else
                    acc <= acc_step;
`endif
                end
                FIX: begin
                    done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                    if (is_div && div_zero) begin
                        lo_q <= '1;
                        hi_q <= a_orig;
                    end else if (is_div) begin
                        lo_q <= quo;
                        hi_q <= rem;
                    end else begin
                        hi_q <= product[2*W-1:W];
                        lo_q <= product[W-1:0];
                    end
`else
                    hi_q <= product[2*W-1:W];
                    lo_q <= product[W-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic HI/LO model; DIV expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [2:0]  md_op = '0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_in   (a_in),
        .b_in   (b_in),
        .md_op  (md_op),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Architectural result of one request, from plain signed/unsigned arithmetic.
    task automatic refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output bit long_op);
        logic signed [63:0] sa, sb, sr;
        logic [63:0]        ua, ub, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        long_op = 1'b0;
        case (op)
            MD_MULT:  begin sr = sa * sb; exp_hi = sr[63:32]; exp_lo = sr[31:0]; long_op = 1'b1; end
            MD_MULTU: begin ur = ua * ub; exp_hi = ur[63:32]; exp_lo = ur[31:0]; long_op = 1'b1; end
`ifdef MULDIV_DIV_EN
            MD_DIV: begin
                long_op = 1'b1;
                if (b == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else begin
                    sr = sa / sb; exp_lo = sr[31:0];
                    sr = sa % sb; exp_hi = sr[31:0];
                end
            end
            MD_DIVU: begin
                long_op = 1'b1;
                if (b == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                end else begin
                    ur = ua / ub; exp_lo = ur[31:0];
                    ur = ua % ub; exp_hi = ur[31:0];
                end
            end
`endif
            MD_MTHI:  exp_hi = a;
            MD_MTLO:  exp_lo = a;
            default:  ;
        endcase
    endtask

    task automatic waitDone(input string tag, input int n0);
        int n = n0;
        bit busy_ok = 1'b1;
        while (done !== 1'b1 && n < 80) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, n, 34);
        checkOutput({tag, " busy_held"}, busy_ok, 1);
        checkOutput({tag, " busy_at_done"}, busy, 0);
        checkOutput({tag, " hi"}, hi_out, exp_hi);
        checkOutput({tag, " lo"}, lo_out, exp_lo);
    endtask

    // Presents one request at the current negedge and checks its outcome.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string tag);
        bit long_op;
        refModel(op, a, b, long_op);
        md_op = op;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        if (long_op) begin
            waitDone(tag, 1);
        end else begin
            checkOutput({tag, " busy"}, busy, 0);
            checkOutput({tag, " done"}, done, 0);
            checkOutput({tag, " hi"}, hi_out, exp_hi);
            checkOutput({tag, " lo"}, lo_out, exp_lo);
        end
    endtask

    initial begin
        bit          long_op;
        bit          saw_activity;
        logic [2:0]  op;
        logic [31:0] ra, rb;

        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset hi", hi_out, 0);
        checkOutput("reset lo", lo_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
        checkOutput("mult const hi", hi_out, 32'hFFFF_FFFF);
        checkOutput("mult const lo", lo_out, 32'hFFFF_FFFA);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, "multu_b2b");
        checkOutput("multu const hi", hi_out, 32'h0000_0002);
        checkOutput("multu const lo", lo_out, 32'hFFFF_FFFA);
        @(negedge clk);
        checkOutput("done pulse width", done, 0);

        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div");
        applyStimulus(MD_DIVU, 32'd100, 32'd7, "divu");
`ifdef MULDIV_DIV_EN
        checkOutput("divu const lo", lo_out, 32'h0000_000E);
        checkOutput("divu const hi", hi_out, 32'h0000_0002);
`endif
        applyStimulus(MD_DIVU, 32'd5, 32'd0, "divu_by_zero");
        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
`ifdef MULDIV_DIV_EN
        checkOutput("div_overflow const lo", lo_out, 32'h8000_0000);
        checkOutput("div_overflow const hi", hi_out, 32'h0000_0000);
`endif

        applyStimulus(MD_MTHI, 32'h1234_5678, 32'h0, "mthi");
        checkOutput("mthi const hi", hi_out, 32'h1234_5678);
        applyStimulus(MD_MTLO, 32'h9ABC_DEF0, 32'h0, "mtlo");
        checkOutput("mtlo const lo", lo_out, 32'h9ABC_DEF0);
        applyStimulus(3'd6, 32'hDEAD_BEEF, 32'h1, "noop6");
        applyStimulus(3'd7, 32'hCAFE_F00D, 32'h2, "noop7");

        $display("[TB] start while busy");
        ra = $urandom;
        rb = $urandom;
        refModel(MD_MULT, ra, rb, long_op);
        md_op = MD_MULT; a_in = ra; b_in = rb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        md_op = MD_MTHI; a_in = $urandom; b_in = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("mult_disturbed", 6);
        applyStimulus(MD_MULTU, $urandom, $urandom, "multu_after_done");

        $display("[TB] reset mid-operation");
        md_op = MD_MULT; a_in = $urandom; b_in = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset hi", hi_out, 0);
        checkOutput("midreset lo", lo_out, 0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_activity = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_activity = 1'b1;
        end
        checkOutput("midreset no done", saw_activity, 0);
        applyStimulus(MD_MULTU, 32'd7, 32'd6, "multu_7x6");
        checkOutput("multu_7x6 const lo", lo_out, 32'h0000_002A);
        checkOutput("multu_7x6 const hi", hi_out, 32'h0000_0000);

        $display("[TB] randomized requests");
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            applyStimulus(op, ra, rb, $sformatf("rand%0d op%0d", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit beside the ALU in the execute stage. It takes the same two register operands as the ALU and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over multiple cycles, and handles MTHI/MTLO in one cycle. HI/LO feed the writeback mux for MFHI/MFLO. `busy` stalls the CPU while an operation is in flight.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a_in  input  DATA_WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b_in  input  DATA_WIDTH  rt operand: multiplier or divisor.
- md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- start  input  1  request strobe; sampled only in IDLE.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse after HI/LO are updated by MULT/DIV.
- hi_out  output  DATA_WIDTH  HI register.
- lo_out  output  DATA_WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1 with op 0–3:
  - Latch operand magnitudes. Signed ops use two's-complement absolute value; unsigned ops pass the operand through.
  - Latch the result-sign flags and a divide-by-zero flag (b_in==0).
  - Clear the 6-bit counter and go to CALC.
- IDLE, start=1 with op 4/5: write a_in to HI or LO at that edge. State stays IDLE; busy and done stay low.
- IDLE, start=1 with op 6/7: no effect.
- CALC:
  - Multiply is radix-2 shift-add on a 64-bit accumulator.
  - Divide is restoring: each step is a 33-bit trial subtraction, giving one quotient bit.
  - Counter increments each cycle; leaving CALC when the count reaches 31 gives 32 iterations.
- FIX applies sign correction and writes HI/LO, then returns to IDLE.
  - Multiply: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - Divide by zero (signed or unsigned): LO = 32'hFFFFFFFF, HI = original a_in.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 32'h80000000, HI = 0. This falls out of the magnitude arithmetic; no special case.
- start while busy is ignored. Operands are not required to stay stable after the accepting edge.
- Reset (async, any time, including mid-operation):
  - Registers: state = IDLE, HI = 0, LO = 0, counter = 0.
  - Outputs: busy = 0, done = 0.
  - Any in-flight result is discarded.

## Timing
- Edge T accepts start: busy is high for cycles T+1 through T+33 (33 cycles).
- HI/LO update at edge T+33; done is high for exactly the cycle after T+33.
- busy falls in the same cycle that done rises.
- A new start may be accepted at edge T+34 (back-to-back, no bubble).
- MTHI/MTLO: written value is visible on hi_out/lo_out in the cycle after the edge.
- hi_out/lo_out are register outputs with no combinational path from the inputs.
- busy and done are decoded from registered state only.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU are supported as above.
- MULDIV_DIV_EN undefined:
  - The divide datapath is removed.
  - DIV/DIVU behave as no-ops: no busy, no done, HI/LO unchanged.
  - MULT/MULTU/MTHI/MTLO are unaffected.

## Structure
- Package muldiv_pkg holds:
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the state enum (IDLE/CALC/FIX);
  - the iteration count constant MD_ITER = 32.
- Sub-module muldiv_step: combinational single iteration. It takes the accumulator and operands, returns the next accumulator and, for divide, the quotient bit. It is instantiated once in muldiv_unit.
- Sequencer, counter, sign logic and HI/LO registers live in muldiv_unit.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → HI=FFFFFFFF, LO=FFFFFFFA. MULTU on the same operands → HI=00000002, LO=FFFFFFFA. done arrives 33 cycles after the accepting edge.
- DIV 0xFFFFFFF9 / 0x00000002 → LO=FFFFFFFD, HI=FFFFFFFF. DIVU 100 / 7 → LO=0000000E, HI=00000002.
- DIVU 5 / 0 → LO=FFFFFFFF, HI=00000005. DIV 0x80000000 / 0xFFFFFFFF → LO=80000000, HI=00000000.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 → hi_out/lo_out update one cycle later; busy stays 0, done stays 0.
- Second start issued mid-MULT → ignored, first result correct. Next start is accepted in the cycle done is high.
- rst_n pulsed low at CALC cycle 10 → busy=0 and HI=LO=0 immediately, no done. A following MULTU 7 × 6 gives LO=0000002A, HI=0.
